pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register that replaces per-operand EX latches with one multi-channel stage.
- Carries NUM_CH data fields of DATA_W bits each, plus a valid bit.
- Supports the existing bubble (hold) and flush controls, and adds a valid/ready handshake with an optional 2-entry skid buffer, so a stage can absorb downstream backpressure without a combinational ready path.
- Saturating stall and flush counters are exposed for performance debug.

---
 rtl/pipe_stage_reg.sv | 92 +++++++++
 tb/tb_pipe_stage_reg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Multi-channel pipeline stage register with valid/ready handshake, optional skid
// buffer, bubble/flush controls and saturating stall/flush counters.
module pipe_stage_reg #(
   parameter int unsigned       NUM_CH    = 2,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       SKID      = 1,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bubble_i,
   input  logic                     flush_i,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         flush_cnt
);

   localparam int unsigned       BUS_W    = NUM_CH * DATA_W;
   localparam logic [BUS_W-1:0]  RST_DATA = {NUM_CH{RESET_VAL}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   logic             m_valid;
   logic             s_valid;
   logic [BUS_W-1:0] m_data;
   logic [BUS_W-1:0] s_data;
   logic             in_fire;
   logic             out_fire;

   // Bubble masks both handshakes; with a skid, ready comes straight from a flop.
   assign in_ready  = (SKID != 0) ? (!bubble_i && !s_valid)
                                  : (!bubble_i && (!m_valid || out_ready));
   assign out_valid = m_valid && !bubble_i;
   assign out_data  = m_data;
   assign in_fire   = in_valid && in_ready && !flush_i;
   assign out_fire  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid   <= 1'b0;
         s_valid   <= 1'b0;
         m_data    <= RST_DATA;
         s_data    <= RST_DATA;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (bubble_i) begin
         m_valid <= m_valid;
      end else if (flush_i) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_data  <= RST_DATA;
         s_data  <= RST_DATA;
         if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
         if (m_valid && !out_ready && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_W'(1);

         if (SKID != 0) begin
            // Main refills from the skid first to keep FIFO order.
            if (!m_valid || out_fire) begin
               if (s_valid) begin
                  m_valid <= 1'b1;
                  m_data  <= s_data;
                  s_valid <= in_fire;
                  if (in_fire) s_data <= in_data;
               end else if (in_fire) begin
                  m_valid <= 1'b1;
                  m_data  <= in_data;
               end else begin
                  m_valid <= 1'b0;
               end
            end else if (in_fire) begin
               s_valid <= 1'b1;
               s_data  <= in_data;
            end
         end else begin
            if (in_fire) begin
               m_valid <= 1'b1;
               m_data  <= in_data;
            end else if (out_fire) begin
               m_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid variant driven from a vector table with an order
// scoreboard, and a no-skid variant with a narrow counter exercised by hand.
module tb_pipe_stage_reg;

   logic clk = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Skid instance: two 8-bit channels, reset value 0xEE per channel.
   logic        rst0 = 1'b1, bub0 = 1'b0, fl0 = 1'b0, iv0 = 1'b0, ordy0 = 1'b0;
   logic [15:0] d0 = '0;
   logic        ir0, ov0;
   logic [15:0] od0, st0, fc0;

   pipe_stage_reg #(.NUM_CH(2), .DATA_W(8), .SKID(1), .RESET_VAL(8'hEE), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst0), .bubble_i(bub0), .flush_i(fl0),
      .in_valid(iv0), .in_ready(ir0), .in_data(d0),
      .out_valid(ov0), .out_ready(ordy0), .out_data(od0),
      .stall_cnt(st0), .flush_cnt(fc0));

   // No-skid instance: one channel, 2-bit counters.
   logic       rst1 = 1'b1, iv1 = 1'b0, ordy1 = 1'b0;
   logic [7:0] d1 = '0;
   logic       ir1, ov1;
   logic [7:0] od1;
   logic [1:0] st1, fc1;

   pipe_stage_reg #(.NUM_CH(1), .DATA_W(8), .SKID(0), .RESET_VAL(8'h5A), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst1), .bubble_i(1'b0), .flush_i(1'b0),
      .in_valid(iv1), .in_ready(ir1), .in_data(d1),
      .out_valid(ov1), .out_ready(ordy1), .out_data(od1),
      .stall_cnt(st1), .flush_cnt(fc1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst, bub, fl, iv;
      logic [15:0] d;
      logic        ordy, chk, ov, ir, chkd;
      logic [15:0] od, st, fc;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic rst, logic bub, logic fl, logic iv, logic [15:0] d,
                               logic ordy, logic chk, logic ov, logic ir, logic chkd,
                               logic [15:0] od, logic [15:0] st, logic [15:0] fc);
      vec_t v;
      v.rst = rst; v.bub = bub; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
      v.chk = chk; v.ov = ov; v.ir = ir; v.chkd = chkd; v.od = od; v.st = st; v.fc = fc;
      return v;
   endfunction

   // Order scoreboard: accepted inputs queued, popped when the stage emits.
   logic [15:0] sb[$];
   always @(posedge clk) begin
      if (rst0) sb.delete();
      else if (!bub0) begin
         if (fl0) sb.delete();
         else begin
            if (ov0 && ordy0) begin
               if (sb.size() == 0) check("sb underflow", 32'd1, 32'd0);
               else check("sb order", 32'(od0), 32'(sb.pop_front()));
            end
            if (iv0 && ir0) sb.push_back(d0);
         end
      end
   end

   task automatic step1(input logic iv, input logic [7:0] d, input logic ordy);
      iv1 = iv; d1 = d; ordy1 = ordy;
      @(negedge clk);
   endtask

   initial begin
      // rows: rst bub fl iv data ordy | chk ov ir chkd out_data stall flush (pre-edge view)
      tv.push_back(mk(1,0,0,1,16'h1111,1, 0,0,0,0,16'h0000,0,0));
      tv.push_back(mk(1,0,0,1,16'h1111,1, 1,0,1,1,16'hEEEE,0,0));
      tv.push_back(mk(0,0,0,0,16'h0000,1, 1,0,1,1,16'hEEEE,0,0));
      tv.push_back(mk(0,0,0,1,16'h11A0,1, 1,0,1,0,16'h0000,0,0));
      tv.push_back(mk(0,0,0,1,16'h12A1,1, 1,1,1,1,16'h11A0,0,0));
      tv.push_back(mk(0,0,0,1,16'h13A2,1, 1,1,1,1,16'h12A1,0,0));
      tv.push_back(mk(0,0,0,0,16'h0000,1, 1,1,1,1,16'h13A2,0,0));
      tv.push_back(mk(0,0,0,0,16'h0000,1, 1,0,1,0,16'h0000,0,0));
      tv.push_back(mk(0,0,0,1,16'h0001,1, 1,0,1,0,16'h0000,0,0));
      tv.push_back(mk(0,0,0,1,16'h0002,0, 1,1,1,1,16'h0001,0,0));
      tv.push_back(mk(0,0,0,1,16'h0003,0, 1,1,0,1,16'h0001,1,0));
      tv.push_back(mk(0,0,0,1,16'h0003,0, 1,1,0,1,16'h0001,2,0));
      tv.push_back(mk(0,0,0,1,16'h0003,1, 1,1,0,1,16'h0001,3,0));
      tv.push_back(mk(0,0,0,1,16'h0003,1, 1,1,1,1,16'h0002,3,0));
      tv.push_back(mk(0,0,0,0,16'h0000,1, 1,1,1,1,16'h0003,3,0));
      tv.push_back(mk(0,0,0,0,16'h0000,1, 1,0,1,0,16'h0000,3,0));
      tv.push_back(mk(0,0,0,1,16'h0021,0, 1,0,1,0,16'h0000,3,0));
      tv.push_back(mk(0,0,0,1,16'h0022,0, 1,1,1,1,16'h0021,3,0));
      tv.push_back(mk(0,0,1,1,16'h0055,0, 1,1,0,1,16'h0021,4,0));
      tv.push_back(mk(0,0,0,0,16'h0000,1, 1,0,1,1,16'hEEEE,4,1));
      tv.push_back(mk(0,0,1,1,16'h0055,1, 1,0,1,1,16'hEEEE,4,1));
      tv.push_back(mk(0,0,0,0,16'h0000,1, 1,0,1,1,16'hEEEE,4,2));
      tv.push_back(mk(0,0,0,1,16'h0007,1, 1,0,1,0,16'h0000,4,2));
      tv.push_back(mk(0,1,1,1,16'h0077,1, 1,0,0,1,16'h0007,4,2));
      tv.push_back(mk(0,1,1,1,16'h0077,0, 1,0,0,1,16'h0007,4,2));
      tv.push_back(mk(0,0,0,0,16'h0000,0, 1,1,1,1,16'h0007,4,2));
      tv.push_back(mk(0,0,0,0,16'h0000,1, 1,1,1,1,16'h0007,5,2));
      tv.push_back(mk(0,0,0,0,16'h0000,1, 1,0,1,0,16'h0000,5,2));
      tv.push_back(mk(0,0,0,1,16'h0099,0, 1,0,1,0,16'h0000,5,2));
      tv.push_back(mk(1,0,0,1,16'h0099,0, 1,1,1,1,16'h0099,5,2));
      tv.push_back(mk(0,0,0,0,16'h0000,1, 1,0,1,1,16'hEEEE,0,0));

      for (int i = 0; i < tv.size(); i++) begin
         rst0 = tv[i].rst; bub0 = tv[i].bub; fl0 = tv[i].fl;
         iv0 = tv[i].iv; d0 = tv[i].d; ordy0 = tv[i].ordy;
         @(negedge clk);
         if (tv[i].chk) begin
            check($sformatf("row%0d out_valid", i), 32'(ov0), 32'(tv[i].ov));
            check($sformatf("row%0d in_ready", i), 32'(ir0), 32'(tv[i].ir));
            check($sformatf("row%0d stall_cnt", i), 32'(st0), 32'(tv[i].st));
            check($sformatf("row%0d flush_cnt", i), 32'(fc0), 32'(tv[i].fc));
            if (tv[i].chkd) check($sformatf("row%0d out_data", i), 32'(od0), 32'(tv[i].od));
         end
         @(posedge clk); #1;
      end
      iv0 = 1'b0; ordy0 = 1'b0;
      check("sb drained", 32'(sb.size()), 32'd0);

      // No-skid stage: combinational ready, counter saturation, back-to-back flow.
      rst1 = 1'b0;
      step1(1'b0, 8'h00, 1'b0);
      check("ns reset out_valid", 32'(ov1), 32'd0);
      check("ns reset out_data", 32'(od1), 32'h5A);
      check("ns reset in_ready", 32'(ir1), 32'd1);
      check("ns reset stall_cnt", 32'(st1), 32'd0);
      @(posedge clk); #1;
      step1(1'b1, 8'h01, 1'b0);
      check("ns empty in_ready", 32'(ir1), 32'd1);
      @(posedge clk); #1;
      step1(1'b1, 8'h02, 1'b0);
      check("ns full out_valid", 32'(ov1), 32'd1);
      check("ns blocked in_ready", 32'(ir1), 32'd0);
      check("ns held data", 32'(od1), 32'h01);
      @(posedge clk); #1;
      for (int k = 1; k <= 5; k++) begin
         step1(1'b0, 8'h00, 1'b0);
         check($sformatf("ns stall_cnt k%0d", k), 32'(st1), (k < 3) ? 32'(k) : 32'd3);
         @(posedge clk); #1;
      end
      step1(1'b1, 8'h02, 1'b1);
      check("ns sat stall_cnt", 32'(st1), 32'd3);
      check("ns ready w/ out_ready", 32'(ir1), 32'd1);
      check("ns out 01", 32'(od1), 32'h01);
      @(posedge clk); #1;
      step1(1'b1, 8'h03, 1'b1);
      check("ns b2b ready", 32'(ir1), 32'd1);
      check("ns b2b valid", 32'(ov1), 32'd1);
      check("ns out 02", 32'(od1), 32'h02);
      @(posedge clk); #1;
      step1(1'b0, 8'h00, 1'b1);
      check("ns out 03", 32'(od1), 32'h03);
      check("ns out 03 valid", 32'(ov1), 32'd1);
      @(posedge clk); #1;
      step1(1'b0, 8'h00, 1'b1);
      check("ns drained", 32'(ov1), 32'd0);
      check("ns flush_cnt", 32'(fc1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
